// File: rtl/pipe_exc_ctrl.sv
// Pipeline stall/flush and exception controller for the 5-stage CPU.
// Commits MEM-stage exceptions, EXRT returns and CR writes, and owns the CR file.
module pipe_exc_ctrl #(
   parameter logic [29:0] EXP_VECTOR = 30'h0000_0100,
   parameter int          IRQ_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             if_busy,
   input  logic             mem_busy,
   input  logic             ld_hazard,
   input  logic [IRQ_W-1:0] irq,
   input  logic             mem_en,
   input  logic [29:0]      mem_pc,
   input  logic             mem_br_flag,
   input  logic [2:0]       mem_exp_code,
   input  logic [1:0]       mem_ctrl_op,
   input  logic [4:0]       mem_cr_addr,
   input  logic [31:0]      mem_wr_data,
   input  logic [4:0]       cr_rd_addr,
   output logic [31:0]      cr_rd_data,
   output logic             if_stall,
   output logic             id_stall,
   output logic             ex_stall,
   output logic             mem_stall,
   output logic             if_flush,
   output logic             id_flush,
   output logic             ex_flush,
   output logic             mem_flush,
   output logic [29:0]      new_pc,
   output logic             int_detect,
   output logic             exe_mode
);

   localparam logic [1:0] OP_WRCR = 2'd1;
   localparam logic [1:0] OP_EXRT = 2'd2;

   logic             r_int_en;
   logic             r_exe_mode;
   logic             r_pre_int_en;
   logic             r_pre_mode;
   logic [IRQ_W-1:0] r_int_mask;
   logic [2:0]       r_exp_code;
   logic [29:0]      r_epc;
   logic [29:0]      r_vector;
   logic [IRQ_W-1:0] r_irq_m;
   logic [IRQ_W-1:0] r_irq_s;

   logic w_busy;
   logic w_no_exc;
   logic w_exc;
   logic w_exrt;
   logic w_wrcr;

   assign w_busy   = if_busy | mem_busy;
   assign w_no_exc = (mem_exp_code == 3'd0);
   // An exception on the MEM instruction overrides any EXRT/WRCR it carries.
   assign w_exc    = mem_en & ~w_no_exc & ~w_busy;
   assign w_exrt   = mem_en & w_no_exc & (mem_ctrl_op == OP_EXRT) & ~w_busy;
   assign w_wrcr   = mem_en & w_no_exc & (mem_ctrl_op == OP_WRCR) & ~w_busy;

   assign int_detect = r_int_en & |(r_irq_s & ~r_int_mask);
   assign exe_mode   = r_exe_mode;
   assign new_pc     = w_no_exc ? r_epc : r_vector;

   always_comb begin
      if_stall  = 1'b0;
      id_stall  = 1'b0;
      ex_stall  = 1'b0;
      mem_stall = 1'b0;
      if_flush  = 1'b0;
      id_flush  = 1'b0;
      ex_flush  = 1'b0;
      mem_flush = 1'b0;
      if (w_busy) begin
         if_stall  = 1'b1;
         id_stall  = 1'b1;
         ex_stall  = 1'b1;
         mem_stall = 1'b1;
      end else if (w_exc || w_exrt) begin
         if_flush  = 1'b1;
         id_flush  = 1'b1;
         ex_flush  = 1'b1;
         mem_flush = 1'b1;
      end else if (ld_hazard) begin
         if_stall = 1'b1;
         id_stall = 1'b1;
         ex_flush = 1'b1;
      end
   end

   // Reads see the registered value; a same-cycle WRCR is not bypassed.
   always_comb begin
      cr_rd_data = 32'd0;
      case (cr_rd_addr)
         5'd0: cr_rd_data = {30'd0, r_int_en, r_exe_mode};
         5'd1: cr_rd_data = {30'd0, r_pre_int_en, r_pre_mode};
         5'd2: cr_rd_data = 32'(r_int_mask);
         5'd3: cr_rd_data = {29'd0, r_exp_code};
         5'd4: cr_rd_data = {r_epc, 2'b00};
         5'd5: cr_rd_data = {r_vector, 2'b00};
         default: cr_rd_data = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_int_en     <= 1'b0;
         r_exe_mode   <= 1'b0;
         r_pre_int_en <= 1'b0;
         r_pre_mode   <= 1'b0;
         r_int_mask   <= '1;
         r_exp_code   <= 3'd0;
         r_epc        <= 30'd0;
         r_vector     <= EXP_VECTOR;
         r_irq_m      <= '0;
         r_irq_s      <= '0;
      end else begin
         r_irq_m <= irq;
         r_irq_s <= r_irq_m;
         if (w_exc) begin
            r_exp_code   <= mem_exp_code;
            r_epc        <= mem_br_flag ? mem_pc - 30'd1 : mem_pc;
            r_pre_int_en <= r_int_en;
            r_pre_mode   <= r_exe_mode;
            r_int_en     <= 1'b0;
            r_exe_mode   <= 1'b0;
         end else if (w_exrt) begin
            r_int_en   <= r_pre_int_en;
            r_exe_mode <= r_pre_mode;
         end else if (w_wrcr) begin
            case (mem_cr_addr)
               5'd0: begin
                  r_int_en   <= mem_wr_data[1];
                  r_exe_mode <= mem_wr_data[0];
               end
               5'd1: begin
                  r_pre_int_en <= mem_wr_data[1];
                  r_pre_mode   <= mem_wr_data[0];
               end
               5'd2: r_int_mask <= mem_wr_data[IRQ_W-1:0];
               5'd3: r_exp_code <= mem_wr_data[2:0];
               5'd4: r_epc      <= mem_wr_data[31:2];
               5'd5: r_vector   <= mem_wr_data[31:2];
               default: ;
            endcase
         end
      end
   end

endmodule
